// File: rtl/cal_seq_ctrl.sv
// Command sequencer between the UART command decoder and the shared ALU.
// It captures, validates and issues decoded commands, and returns exactly one
// result/status word per accepted command. A one-deep pending slot holds one
// command that arrives while the sequencer is busy.
module cal_seq_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TMR_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_done,
  input  logic [3:0]  dec_dtype,
  input  logic [4:0]  dec_op,
  input  logic [15:0] dec_src1,
  input  logic [15:0] dec_src2,
  output logic        alu_start,
  output logic [4:0]  alu_op,
  output logic        alu_signed,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic        alu_done,
  input  logic [31:0] alu_result,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  output logic [1:0]  tx_status,
  input  logic        tx_ready,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StIssue,
    StWait,
    StSend
  } state_e;

  localparam logic [1:0] StatOk      = 2'b00;
  localparam logic [1:0] StatDivZero = 2'b01;
  localparam logic [1:0] StatBadCmd  = 2'b10;
  localparam logic [1:0] StatTimeout = 2'b11;

  state_e      state_q, state_d;
  logic [3:0]  act_dtype_q, act_dtype_d;
  logic [4:0]  act_op_q, act_op_d;
  logic [15:0] act_a_q, act_a_d;
  logic [15:0] act_b_q, act_b_d;
  logic        slot_full_q, slot_full_d;
  logic [3:0]  slot_dtype_q, slot_dtype_d;
  logic [4:0]  slot_op_q, slot_op_d;
  logic [15:0] slot_a_q, slot_a_d;
  logic [15:0] slot_b_q, slot_b_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [31:0] tx_data_q, tx_data_d;
  logic [1:0]  tx_status_q, tx_status_d;
  logic        overrun_q, overrun_d;

  logic op_ok, dtype_ok;

  assign op_ok    = (act_op_q == 5'h01) || (act_op_q == 5'h02) ||
                    (act_op_q == 5'h04) || (act_op_q == 5'h08);
  assign dtype_ok = (act_dtype_q == 4'd1) || (act_dtype_q == 4'd2);

  // Next-state logic for the FSM, held command registers, pending slot and response.
  always_comb begin
    state_d      = state_q;
    act_dtype_d  = act_dtype_q;
    act_op_d     = act_op_q;
    act_a_d      = act_a_q;
    act_b_d      = act_b_q;
    slot_full_d  = slot_full_q;
    slot_dtype_d = slot_dtype_q;
    slot_op_d    = slot_op_q;
    slot_a_d     = slot_a_q;
    slot_b_d     = slot_b_q;
    timer_d      = timer_q;
    tx_data_d    = tx_data_q;
    tx_status_d  = tx_status_q;
    overrun_d    = overrun_q;

    case (state_q)
      StIdle: begin
        if (slot_full_q) begin
          act_dtype_d = slot_dtype_q;
          act_op_d    = slot_op_q;
          act_a_d     = slot_a_q;
          act_b_d     = slot_b_q;
          slot_full_d = 1'b0;
          state_d     = StCheck;
          // The slot is freed this cycle, so a new command can land in it.
          if (dec_done) begin
            slot_full_d  = 1'b1;
            slot_dtype_d = dec_dtype;
            slot_op_d    = dec_op;
            slot_a_d     = dec_src1;
            slot_b_d     = dec_src2;
          end
        end else if (dec_done) begin
          act_dtype_d = dec_dtype;
          act_op_d    = dec_op;
          act_a_d     = dec_src1;
          act_b_d     = dec_src2;
          state_d     = StCheck;
        end
      end
      StCheck: begin
        if (!op_ok || !dtype_ok) begin
          tx_status_d = StatBadCmd;
          tx_data_d   = 32'd0;
          state_d     = StSend;
        end else if ((act_op_q == 5'h08) && (act_b_q == 16'd0)) begin
          tx_status_d = StatDivZero;
          tx_data_d   = 32'd0;
          state_d     = StSend;
        end else begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        // A result arriving on the last allowed cycle still counts.
        if (alu_done) begin
          tx_data_d   = alu_result;
          tx_status_d = StatOk;
          state_d     = StSend;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          tx_data_d   = 32'd0;
          tx_status_d = StatTimeout;
          state_d     = StSend;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      StSend: begin
        if (tx_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (dec_done && (state_q != StIdle)) begin
      if (!slot_full_q) begin
        slot_full_d  = 1'b1;
        slot_dtype_d = dec_dtype;
        slot_op_d    = dec_op;
        slot_a_d     = dec_src1;
        slot_b_d     = dec_src2;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      act_dtype_q  <= '0;
      act_op_q     <= '0;
      act_a_q      <= '0;
      act_b_q      <= '0;
      slot_full_q  <= 1'b0;
      slot_dtype_q <= '0;
      slot_op_q    <= '0;
      slot_a_q     <= '0;
      slot_b_q     <= '0;
      timer_q      <= '0;
      tx_data_q    <= '0;
      tx_status_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_dtype_q  <= act_dtype_d;
      act_op_q     <= act_op_d;
      act_a_q      <= act_a_d;
      act_b_q      <= act_b_d;
      slot_full_q  <= slot_full_d;
      slot_dtype_q <= slot_dtype_d;
      slot_op_q    <= slot_op_d;
      slot_a_q     <= slot_a_d;
      slot_b_q     <= slot_b_d;
      timer_q      <= timer_d;
      tx_data_q    <= tx_data_d;
      tx_status_q  <= tx_status_d;
      overrun_q    <= overrun_d;
    end
  end

  assign alu_start  = (state_q == StIssue);
  assign alu_op     = act_op_q;
  assign alu_signed = (act_dtype_q == 4'd2);
  assign alu_a      = act_a_q;
  assign alu_b      = act_b_q;
  assign tx_valid   = (state_q == StSend);
  assign tx_data    = tx_data_q;
  assign tx_status  = tx_status_q;
  assign busy       = (state_q != StIdle) || slot_full_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/cal_seq_ctrl.md
Name: cal_seq_ctrl

Overview:
Command sequencer between the UART command decoder and the shared arithmetic unit of the UART calculator. It captures each decoded command (dtype, op, src1, src2) on the decoder's done pulse and validates it. Valid commands are issued to the ALU and the result is awaited under a timeout. Every command produces exactly one result/status word to the UART response formatter over a valid/ready handshake. A one-deep pending slot absorbs one command arriving while busy.

Parameters:
TIMEOUT, 64, max cycles spent in WAIT_ALU before abort (must be >= 2)
TMR_W, 8, timer width; TIMEOUT must fit in TMR_W bits

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
dec_done  input  1  one-cycle pulse: decoded command valid this cycle
dec_dtype  input  4  1 = unsigned, 2 = signed, other = invalid
dec_op  input  5  one-hot op: 01 add, 02 sub, 04 mul, 08 div
dec_src1  input  16  operand A
dec_src2  input  16  operand B
alu_start  output  1  one-cycle start pulse to ALU
alu_op  output  5  op to ALU, stable from ISSUE through end of WAIT_ALU
alu_signed  output  1  1 when dtype = 2
alu_a  output  16  operand A to ALU
alu_b  output  16  operand B to ALU
alu_done  input  1  ALU result valid pulse; ignored outside WAIT_ALU
alu_result  input  32  ALU result, sampled when alu_done = 1
tx_valid  output  1  response available
tx_data  output  32  result (0 for any error status)
tx_status  output  2  00 ok, 01 divide-by-zero, 10 bad command, 11 ALU timeout
tx_ready  input  1  formatter accepts response when tx_valid & tx_ready
busy  output  1  state != IDLE or pending slot occupied
overrun  output  1  sticky; set when a command is dropped, cleared only by rst

Behaviour:
- Reset: state IDLE; pending slot empty; timer 0; all outputs 0, including overrun and all held registers.
- States: IDLE, CHECK, ISSUE, WAIT_ALU, SEND.
- IDLE, slot full: load active registers from slot, clear slot, go CHECK. A dec_done in the same cycle writes the now-free slot.
- IDLE, slot empty, dec_done: load active registers directly from dec_* inputs, go CHECK.
- dec_done in any other state: written to slot if empty; if slot full, command dropped and overrun set to 1.
- CHECK (1 cycle), evaluated in this order:
  - op not in {01,02,04,08} or dtype not in {1,2}: status 10, go SEND.
  - Else op = 08 and src2 = 0: status 01, go SEND.
  - Else go ISSUE.
- ISSUE (1 cycle): alu_start = 1; go WAIT_ALU; timer cleared to 0. alu_op, alu_a, alu_b and alu_signed are driven from the active registers at all times and stay constant until the next load.
- WAIT_ALU:
  - alu_done = 1: capture alu_result into tx_data, status 00, go SEND.
  - Else if timer = TIMEOUT-1: status 11, tx_data 0, go SEND.
  - Else timer increments.
  - alu_done wins if it coincides with the timeout cycle.
- SEND:
  - tx_valid = 1; tx_data and tx_status held stable until accepted.
  - On tx_valid & tx_ready: tx_valid drops the next cycle, state goes IDLE.
  - No timeout on tx_ready.
- Latency, dec_done at cycle 0 from an empty IDLE: CHECK at 1, alu_start at 2, earliest alu_done at 3, tx_valid from 4. Error paths: tx_valid from 2.
- Back-to-back pending command: IDLE lasts 1 cycle after acceptance, then CHECK.
- tx_data and tx_status are written only on entry to SEND and hold their value in all other states.
- rst mid-operation aborts everything to the reset state; an in-flight ALU result is discarded.

Test Plan:
1. Unsigned add: dec_done with dtype 1, op 01, src1 0x1234, src2 0x0011; ALU returns 0x1245 two cycles after start -> exactly one alu_start at cycle 2, alu_signed 0; tx_valid with tx_data 0x00001245, status 00; clears after the tx_ready handshake.
2. Divide by zero: op 08, dtype 2, src2 0 -> no alu_start; tx_valid at cycle 2 with tx_data 0, status 01.
3. Bad command: op 03 (dtype 1), then op 01 with dtype 5 -> each returns status 10, no alu_start.
4. Timeout: ALU never asserts done, TIMEOUT 64 -> status 11 exactly 64 cycles after entering WAIT_ALU. Variant with alu_done on the final cycle -> status 00.
5. Pending/overrun: three dec_done pulses while WAIT_ALU and tx_ready is held low -> second command is executed after the first is accepted; third is dropped; overrun = 1 and stays 1; busy stays high until the second response is accepted.
6. Reset mid-WAIT_ALU with the slot full -> next cycle: IDLE, busy 0, overrun 0, tx_valid 0; a late alu_done is ignored.
